// File: rtl/fan_tachometer.sv
// Fan tachometer: synchronizes and debounces each raw tach input, counts
// filtered rising edges over a fixed gate window, and latches a scaled RPM
// value plus a stall flag per fan at the end of every window.
module fan_tachometer #(
    parameter int NUM_FANS        = 2,
    parameter int GATE_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_WIDTH      = 12,
    parameter int RPM_SCALE       = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FANS-1:0]     fan_tach,
    output logic [16*NUM_FANS-1:0]  rpm,
    output logic [NUM_FANS-1:0]     stalled,
    output logic                    rpm_valid
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = EDGE_WIDTH + 16;

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] SCALE     = PW'(RPM_SCALE);
    localparam logic [PW-1:0] RPM_MAX   = PW'(65535);

    logic [GW-1:0] gate_reg;
    logic [GW-1:0] gate_next;
    logic          terminal;
    logic          rpm_valid_reg;

    // Gate window position; terminal marks the last cycle of each window
    always_comb begin
        terminal  = (gate_reg == GATE_LAST);
        gate_next = terminal ? '0 : gate_reg + 1'b1;
    end

    // Gate counter and the one-cycle update strobe that follows the terminal cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_reg      <= '0;
            rpm_valid_reg <= 1'b0;
        end else begin
            gate_reg      <= gate_next;
            rpm_valid_reg <= terminal;
        end
    end

    assign rpm_valid = rpm_valid_reg;

    generate
        for (genvar gi = 0; gi < NUM_FANS; gi++) begin : g_fan
            (* ASYNC_REG = "TRUE" *) logic sync1_reg;
            (* ASYNC_REG = "TRUE" *) logic sync2_reg;
            logic                  f_reg;
            logic                  f_next;
            logic                  f_prev_reg;
            logic [DW-1:0]         d_reg;
            logic [DW-1:0]         d_next;
            logic                  rise;
            logic [EDGE_WIDTH-1:0] edge_reg;
            logic [EDGE_WIDTH-1:0] edge_next;
            logic [PW-1:0]         product;
            logic [15:0]           rpm_reg;
            logic [15:0]           rpm_next;
            logic                  stalled_reg;

            // Debounce, rising-edge detect, saturating edge count and RPM scaling
            always_comb begin
                f_next = f_reg;
                d_next = '0;
                if (sync2_reg != f_reg) begin
                    if (d_reg == DEB_LAST) begin
                        f_next = sync2_reg;
                    end else begin
                        d_next = d_reg + 1'b1;
                    end
                end

                rise = f_reg & ~f_prev_reg;

                // An edge landing in the terminal cycle is carried into the next window
                if (terminal) begin
                    edge_next = EDGE_WIDTH'(rise);
                end else if (rise && (edge_reg != '1)) begin
                    edge_next = edge_reg + 1'b1;
                end else begin
                    edge_next = edge_reg;
                end

                product  = PW'(edge_reg) * SCALE;
                rpm_next = (product > RPM_MAX) ? 16'hFFFF : product[15:0];
            end

            // Per-fan state; results latch only on the terminal cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    f_reg       <= 1'b0;
                    f_prev_reg  <= 1'b0;
                    d_reg       <= '0;
                    edge_reg    <= '0;
                    rpm_reg     <= '0;
                    stalled_reg <= 1'b0;
                end else begin
                    sync1_reg  <= fan_tach[gi];
                    sync2_reg  <= sync1_reg;
                    f_reg      <= f_next;
                    f_prev_reg <= f_reg;
                    d_reg      <= d_next;
                    edge_reg   <= edge_next;
                    if (terminal) begin
                        rpm_reg     <= rpm_next;
                        stalled_reg <= (edge_reg == '0);
                    end
                end
            end

            assign rpm[16*gi +: 16] = rpm_reg;
            assign stalled[gi]      = stalled_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fan_tachometer.sv
// Directed bench for fan_tachometer with a 1000-cycle gate and 4-sample
// debounce; two extra instances cover RPM clamping and edge-count saturation.
module tb_fan_tachometer;

    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  fan_tach = 2'b00;
    logic [31:0] rpm, rpm_c, rpm_s;
    logic [1:0]  stalled, stalled_c, stalled_s;
    logic        rpm_valid, valid_c, valid_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fan_tachometer #(.NUM_FANS(2), .GATE_CYCLES(G), .DEBOUNCE_CYCLES(4),
                     .EDGE_WIDTH(12), .RPM_SCALE(30)) dut (
        .clk(clk), .rst(rst), .fan_tach(fan_tach),
        .rpm(rpm), .stalled(stalled), .rpm_valid(rpm_valid));

    fan_tachometer #(.NUM_FANS(2), .GATE_CYCLES(G), .DEBOUNCE_CYCLES(4),
                     .EDGE_WIDTH(12), .RPM_SCALE(1000)) dut_clamp (
        .clk(clk), .rst(rst), .fan_tach(fan_tach),
        .rpm(rpm_c), .stalled(stalled_c), .rpm_valid(valid_c));

    fan_tachometer #(.NUM_FANS(2), .GATE_CYCLES(G), .DEBOUNCE_CYCLES(4),
                     .EDGE_WIDTH(4), .RPM_SCALE(1000)) dut_sat (
        .clk(clk), .rst(rst), .fan_tach(fan_tach),
        .rpm(rpm_s), .stalled(stalled_s), .rpm_valid(valid_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset released just after a clock edge; the next cycle is gate position 0
    task automatic apply_reset();
        fan_tach = 2'b00;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({rpm, stalled, rpm_valid} !== 35'd0) begin
            errors++;
            $display("FAIL reset_async got rpm=%h stalled=%b valid=%b want 0", rpm, stalled, rpm_valid);
        end
        repeat (3) tick();
        checks++;
        if ({rpm, stalled, rpm_valid} !== 35'd0) begin
            errors++;
            $display("FAIL reset_held got rpm=%h stalled=%b valid=%b want 0", rpm, stalled, rpm_valid);
        end
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (rpm_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_novalid got %b want 0", rpm_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_square_wave();
        int pulses = 0;
        logic b;
        apply_reset();
        for (int k = 0; k < 3*G; k++) begin
            b = ((k % 100) < 50);
            fan_tach = {1'b0, b};
            tick();
            if (rpm_valid === 1'b1) pulses++;
            if ((k + 1) % G == 0) begin
                checks++;
                if (rpm_valid !== 1'b1 || rpm[15:0] !== 16'd300 || rpm[31:16] !== 16'd0 || stalled !== 2'b10) begin
                    errors++;
                    $display("FAIL square_win%0d got valid=%b rpm0=%0d rpm1=%0d stalled=%b want 1/300/0/10",
                             (k + 1) / G, rpm_valid, rpm[15:0], rpm[31:16], stalled);
                end
                $display("square window %0d rpm0=%0d rpm1=%0d stalled=%b", (k + 1) / G, rpm[15:0], rpm[31:16], stalled);
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL square_pulses got %0d want 3", pulses);
        end
    endtask

    task automatic test_glitch();
        logic g, b;
        apply_reset();
        for (int k = 0; k < 2*G; k++) begin
            g = ((k % 50) < 2);
            b = ((k % 100) < 50);
            fan_tach = {b, g};
            tick();
            if ((k + 1) % G == 0) begin
                checks++;
                if (rpm_valid !== 1'b1 || rpm[15:0] !== 16'd0 || rpm[31:16] !== 16'd300 || stalled !== 2'b01) begin
                    errors++;
                    $display("FAIL glitch_win%0d got valid=%b rpm0=%0d rpm1=%0d stalled=%b want 1/0/300/01",
                             (k + 1) / G, rpm_valid, rpm[15:0], rpm[31:16], stalled);
                end
                $display("glitch window %0d rpm0=%0d rpm1=%0d stalled=%b", (k + 1) / G, rpm[15:0], rpm[31:16], stalled);
            end
        end
    endtask

    task automatic test_clamp_saturate();
        logic b;
        apply_reset();
        for (int k = 0; k < 2*G; k++) begin
            b = ((k % 8) < 4);
            fan_tach = {b, b};
            tick();
            if ((k + 1) % G == 0) begin
                checks++;
                if (rpm !== {16'd3750, 16'd3750} || stalled !== 2'b00) begin
                    errors++;
                    $display("FAIL fast_rpm got %h stalled=%b want 3750 each, 00", rpm, stalled);
                end
                checks++;
                if (valid_c !== 1'b1 || rpm_c !== {16'hFFFF, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL clamp_rpm got valid=%b rpm=%h want 1 ffffffff", valid_c, rpm_c);
                end
                checks++;
                if (valid_s !== 1'b1 || rpm_s !== {16'd15000, 16'd15000} || stalled_s !== 2'b00) begin
                    errors++;
                    $display("FAIL sat_rpm got valid=%b rpm=%h stalled=%b want 1, 15000 each, 00", valid_s, rpm_s, stalled_s);
                end
                $display("fast window %0d rpm=%0d clamp=%0d sat=%0d", (k + 1) / G, rpm[15:0], rpm_c[15:0], rpm_s[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        int pulses = 0;
        logic b;
        apply_reset();
        for (int k = 0; k < G + 600; k++) begin
            b = ((k % 100) < 50);
            fan_tach = {1'b0, b};
            tick();
        end
        checks++;
        if (rpm[15:0] !== 16'd300) begin
            errors++;
            $display("FAIL midrst_pre got rpm0=%0d want 300", rpm[15:0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rpm, stalled, rpm_valid} !== 35'd0) begin
            errors++;
            $display("FAIL midrst_clear got rpm=%h stalled=%b valid=%b want 0", rpm, stalled, rpm_valid);
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < G + 100; k++) begin
            b = ((k % 100) < 50);
            fan_tach = {1'b0, b};
            tick();
            if (k + 1 < G && rpm_valid === 1'b1) pulses++;
            if (k + 1 == G) begin
                checks++;
                if (rpm_valid !== 1'b1 || rpm[15:0] !== 16'd300 || stalled !== 2'b10) begin
                    errors++;
                    $display("FAIL midrst_first got valid=%b rpm0=%0d stalled=%b want 1/300/10", rpm_valid, rpm[15:0], stalled);
                end
                $display("reset-mid first window rpm0=%0d", rpm[15:0]);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_early got %0d early strobes want 0", pulses);
        end
    endtask

    // Raw rise at iteration k0 becomes a filtered edge in cycle k0+6; 993 lands on T
    task automatic test_edge_at_terminal();
        int k0_tab[2]  = '{992, 993};
        int w1_tab[2]  = '{30, 0};
        int w2_tab[2]  = '{0, 30};
        for (int c = 0; c < 2; c++) begin
            apply_reset();
            for (int k = 0; k < 2*G; k++) begin
                fan_tach = {1'b0, (k >= k0_tab[c])};
                tick();
                if (k + 1 == G || k + 1 == 2*G) begin
                    checks++;
                    if (rpm_valid !== 1'b1 || rpm[15:0] !== 16'((k + 1 == G) ? w1_tab[c] : w2_tab[c]) ||
                        stalled[0] !== (((k + 1 == G) ? w1_tab[c] : w2_tab[c]) == 0)) begin
                        errors++;
                        $display("FAIL edgeT_k%0d_win%0d got valid=%b rpm0=%0d stalled0=%b want rpm0=%0d",
                                 k0_tab[c], (k + 1) / G, rpm_valid, rpm[15:0], stalled[0],
                                 (k + 1 == G) ? w1_tab[c] : w2_tab[c]);
                    end
                    $display("edge-at-T k0=%0d window %0d rpm0=%0d", k0_tab[c], (k + 1) / G, rpm[15:0]);
                end
            end
        end
    endtask

    task automatic test_random_phase();
        logic lvl = 1'b0;
        apply_reset();
        for (int k = 0; k < 3*G; k++) begin
            if (k % 50 == 0) begin
                #($urandom_range(0, 7));
                lvl = ~lvl;
                fan_tach = {~lvl, lvl};
            end
            tick();
            if ((k + 1) % G == 0) begin
                checks++;
                if ($isunknown({rpm, stalled, rpm_valid}) || rpm_valid !== 1'b1 ||
                    rpm[15:0] < 16'd270 || rpm[15:0] > 16'd330 ||
                    rpm[31:16] < 16'd270 || rpm[31:16] > 16'd330) begin
                    errors++;
                    $display("FAIL random_win%0d got valid=%b rpm0=%0d rpm1=%0d want 270..330",
                             (k + 1) / G, rpm_valid, rpm[15:0], rpm[31:16]);
                end
                $display("random window %0d rpm0=%0d rpm1=%0d", (k + 1) / G, rpm[15:0], rpm[31:16]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_square_wave();
        test_glitch();
        test_clamp_saturate();
        test_reset_mid_window();
        test_edge_at_terminal();
        test_random_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
